// File: rtl/video_in_frame_sched.sv
// Frame-buffer ring scheduler: arms the video store engine per frame and offers the newest
// complete frame to one consumer through claim/release; GO rises two cycles after cfg_en.
module video_in_frame_sched #(
  parameter int p_NB_BUF      = 3,
  parameter int p_FRAME_BYTES = 307200
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        cfg_en,
  input  logic [31:0] cfg_base,
  output logic [31:0] store_ctr,
  output logic [31:0] store_data,
  input  logic        store_irq,
  output logic        frm_valid,
  output logic [31:0] frm_addr,
  input  logic        frm_ready,
  input  logic        frm_release,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
);

  localparam int IW = (p_NB_BUF > 2) ? 2 : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PICK     = 3'd1;
  localparam logic [2:0] S_ARM      = 3'd2;
  localparam logic [2:0] S_CAPTURE  = 3'd3;
  localparam logic [2:0] S_WAIT_LOW = 3'd4;

  localparam logic [1:0] B_FREE  = 2'd0;
  localparam logic [1:0] B_FILL  = 2'd1;
  localparam logic [1:0] B_READY = 2'd2;
  localparam logic [1:0] B_HELD  = 2'd3;

  logic [2:0]                     state;
  logic                           go;
  logic                           arm_last;
  logic                           irq_q;
  logic [p_NB_BUF-1:0][1:0]       buf_st;
  logic [p_NB_BUF-1:0][31:0]      buf_addr;
  logic [p_NB_BUF-1:0][1:0]       st_n;
  logic [p_NB_BUF-1:0][31:0]      addr_n;

  logic          any_held;
  logic          ready_found;
  logic          free_found;
  logic [IW-1:0] ready_idx;
  logic [IW-1:0] free_idx;
  logic [IW-1:0] pick_idx;
  logic [31:0]   pick_addr;
  logic          claim;
  logic          rel;
  logic          eof;
  logic          do_pick;
  logic          drop_inc;
  logic          ready_n;
  logic          held_n;
  logic [31:0]   vaddr_n;

  assign store_ctr = {31'd0, go};

  // Descending scan so the lowest-index FREE buffer wins.
  always_comb begin
    any_held    = 1'b0;
    ready_found = 1'b0;
    free_found  = 1'b0;
    ready_idx   = '0;
    free_idx    = '0;
    for (int i = p_NB_BUF - 1; i >= 0; i--) begin
      if (buf_st[i] == B_HELD) any_held = 1'b1;
      if (buf_st[i] == B_READY) begin
        ready_found = 1'b1;
        ready_idx   = IW'(i);
      end
      if (buf_st[i] == B_FREE) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  assign claim     = frm_valid && frm_ready;
  assign rel       = frm_release && any_held;
  assign eof       = (state == S_CAPTURE) && store_irq && !irq_q;
  // The pick resolves on the edge entering PICK, so store_data settles a full cycle ahead of GO.
  assign do_pick   = cfg_en && ((state == S_IDLE) || ((state == S_WAIT_LOW) && !store_irq));
  assign pick_idx  = free_found ? free_idx : ready_idx;
  assign pick_addr = cfg_base + 32'(p_FRAME_BYTES) * 32'(pick_idx);

  always_comb begin
    st_n     = buf_st;
    addr_n   = buf_addr;
    drop_inc = 1'b0;
    for (int i = 0; i < p_NB_BUF; i++) begin
      if (claim && (buf_st[i] == B_READY)) st_n[i] = B_HELD;
      if (rel && (buf_st[i] == B_HELD)) st_n[i] = B_FREE;
      if (eof) begin
        if (buf_st[i] == B_FILL) begin
          st_n[i] = B_READY;
        end else if ((buf_st[i] == B_READY) && !claim) begin
          st_n[i]  = B_FREE;
          drop_inc = 1'b1;
        end
      end
      if (do_pick && (free_found || ready_found) && (IW'(i) == pick_idx)) begin
        st_n[i]   = B_FILL;
        addr_n[i] = pick_addr;
      end
    end
    if (do_pick && !free_found && ready_found) drop_inc = 1'b1;
  end

  always_comb begin
    ready_n = 1'b0;
    held_n  = 1'b0;
    vaddr_n = frm_addr;
    for (int i = 0; i < p_NB_BUF; i++) begin
      if (st_n[i] == B_READY) begin
        ready_n = 1'b1;
        vaddr_n = addr_n[i];
      end
      if (st_n[i] == B_HELD) held_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      go         <= 1'b0;
      arm_last   <= 1'b0;
      irq_q      <= 1'b0;
      buf_st     <= '0;
      buf_addr   <= '0;
      store_data <= 32'd0;
      busy       <= 1'b0;
      frame_cnt  <= 16'd0;
      drop_cnt   <= 16'd0;
      frm_valid  <= 1'b0;
      frm_addr   <= 32'd0;
    end else begin
      irq_q     <= store_irq;
      buf_st    <= st_n;
      buf_addr  <= addr_n;
      frm_valid <= ready_n && !held_n;
      frm_addr  <= vaddr_n;
      if (eof) frame_cnt <= frame_cnt + 16'd1;
      if (drop_inc && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      if (do_pick) store_data <= pick_addr;
      case (state)
        S_IDLE: begin
          if (cfg_en) state <= S_PICK;
        end
        S_PICK: begin
          state    <= S_ARM;
          go       <= 1'b1;
          busy     <= 1'b1;
          arm_last <= 1'b0;
        end
        S_ARM: begin
          if (arm_last) begin
            state <= S_CAPTURE;
            go    <= 1'b0;
          end else begin
            arm_last <= 1'b1;
          end
        end
        S_CAPTURE: begin
          if (eof) begin
            state <= S_WAIT_LOW;
            busy  <= 1'b0;
          end
        end
        S_WAIT_LOW: begin
          if (!store_irq) state <= cfg_en ? S_PICK : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
